// File: rtl/qrisc32_avalon_arbiter.sv
// rtl/qrisc32_avalon_arbiter.sv - fixed-priority Avalon-MM arbiter for the qrisc32 instr/data-read/data-write ports
// A pending instruction fetch that keeps losing is force-granted after STARVE_LIMIT losses.
module qrisc32_avalon_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_rd,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_wait_req,
   input  logic [ADDR_W-1:0] dr_addr,
   input  logic              dr_rd,
   output logic [DATA_W-1:0] dr_rdata,
   output logic              dr_wait_req,
   input  logic [ADDR_W-1:0] dw_addr,
   input  logic [DATA_W-1:0] dw_wdata,
   input  logic              dw_wr,
   output logic              dw_wait_req,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_rd,
   output logic              m_wr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_wait_req,
   output logic [2:0]        grant
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic {IDLE, XFER} state_t;

   state_t        state_q;
   logic [2:0]    grant_q;
   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;
   logic [2:0]    grant_d;
   logic [2:0]    req;
   logic          granted_req;

   assign req         = {dw_wr, dr_rd, i_rd};
   assign granted_req = |(grant_q & req);

   // Write beats read so a store followed by a load from the MEM stage stays ordered.
   always_comb begin
      grant_d = 3'b000;
      if (i_rd && starve_q == LIMIT) grant_d = 3'b001;
      else if (dw_wr)                grant_d = 3'b100;
      else if (dr_rd)                grant_d = 3'b010;
      else if (i_rd)                 grant_d = 3'b001;
   end

   always_comb begin
      starve_d = '0;
      if (i_rd && !grant_d[0])
         starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= 3'b000;
         starve_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               starve_q <= starve_d;
               if (|req) begin
                  grant_q <= grant_d;
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (!granted_req || !m_wait_req) begin
                  grant_q <= 3'b000;
                  state_q <= IDLE;
               end
            end
            default: begin
               grant_q <= 3'b000;
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_rd    = 1'b0;
      m_wr    = 1'b0;
      if (state_q == XFER) begin
         if (grant_q[2]) begin
            m_addr  = dw_addr;
            m_wdata = dw_wdata;
            m_wr    = dw_wr;
         end else if (grant_q[1]) begin
            m_addr = dr_addr;
            m_rd   = dr_rd;
         end else if (grant_q[0]) begin
            m_addr = i_addr;
            m_rd   = i_rd;
         end
      end
   end

   assign i_wait_req  = i_rd  & (grant_q[0] ? m_wait_req : 1'b1);
   assign dr_wait_req = dr_rd & (grant_q[1] ? m_wait_req : 1'b1);
   assign dw_wait_req = dw_wr & (grant_q[2] ? m_wait_req : 1'b1);

   assign i_rdata  = m_rdata;
   assign dr_rdata = m_rdata;
   assign grant    = grant_q;

endmodule

// File: tb/tb_qrisc32_avalon_arbiter.sv
// tb/tb_qrisc32_avalon_arbiter.sv - table-driven bench for qrisc32_avalon_arbiter
module tb_qrisc32_avalon_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_addr, dr_addr, dw_addr, dw_wdata, m_rdata;
   logic        i_rd, dr_rd, dw_wr, m_wait_req;
   logic [31:0] i_rdata, dr_rdata, m_addr, m_wdata;
   logic        i_wait_req, dr_wait_req, dw_wait_req, m_rd, m_wr;
   logic [2:0]  grant;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   qrisc32_avalon_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
      .clk(clk), .reset(reset),
      .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata), .i_wait_req(i_wait_req),
      .dr_addr(dr_addr), .dr_rd(dr_rd), .dr_rdata(dr_rdata), .dr_wait_req(dr_wait_req),
      .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_wr(dw_wr), .dw_wait_req(dw_wait_req),
      .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_wait_req(m_wait_req), .grant(grant)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        i_rd, dr_rd, dw_wr, mwait;
      logic [31:0] i_addr, dr_addr, dw_addr, dw_wdata, mrdata;
      logic [2:0]  e_grant;
      logic        e_mrd, e_mwr;
      logic [31:0] e_maddr, e_mwdata;
      logic [2:0]  e_wait;   // {dw, dr, i}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic rst, input logic ir, input logic dr,
                               input logic dw, input logic mw, input logic [31:0] dwa,
                               input logic [31:0] dwd, input logic [31:0] rd,
                               input logic [2:0] eg, input logic emr, input logic emw,
                               input logic [31:0] ema, input logic [31:0] emd,
                               input logic [2:0] ew);
      vec_t v;
      v.name = nm; v.rst = rst; v.i_rd = ir; v.dr_rd = dr; v.dw_wr = dw; v.mwait = mw;
      v.i_addr = 32'h100; v.dr_addr = 32'h24; v.dw_addr = dwa; v.dw_wdata = dwd; v.mrdata = rd;
      v.e_grant = eg; v.e_mrd = emr; v.e_mwr = emw; v.e_maddr = ema; v.e_mwdata = emd;
      v.e_wait = ew;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_g [6];
      exp_g = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001};

      reset = 1'b0; i_rd = 1'b0; dr_rd = 1'b0; dw_wr = 1'b0; m_wait_req = 1'b0;
      i_addr = '0; dr_addr = '0; dw_addr = '0; dw_wdata = '0; m_rdata = '0;

      //                 name          rst ir dr dw mw  dw_addr  dw_wdata  m_rdata        grant  mrd mwr m_addr   m_wdata  wait
      vecs.push_back(mk("rst_hold0",   0, 1, 1, 1, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b111));
      vecs.push_back(mk("rst_hold1",   0, 1, 1, 1, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b111));
      vecs.push_back(mk("rst_rel",     1, 1, 1, 1, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b111));
      vecs.push_back(mk("rst_wgrant",  1, 1, 1, 1, 0, 32'h20, 32'h55,   32'h0,        3'b100, 0, 1, 32'h20,  32'h55,  3'b011));
      vecs.push_back(mk("idle_a",      1, 0, 0, 0, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b000));
      vecs.push_back(mk("ird_arb",     1, 1, 0, 0, 0, 32'h20, 32'h55,   32'hDEADBEEF, 3'b000, 0, 0, 32'h0,   32'h0,   3'b001));
      vecs.push_back(mk("ird_xfer",    1, 1, 0, 0, 0, 32'h20, 32'h55,   32'hDEADBEEF, 3'b001, 1, 0, 32'h100, 32'h0,   3'b000));
      vecs.push_back(mk("ird_idle",    1, 0, 0, 0, 0, 32'h20, 32'h55,   32'hDEADBEEF, 3'b000, 0, 0, 32'h0,   32'h0,   3'b000));
      vecs.push_back(mk("rw_arb",      1, 0, 1, 1, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b110));
      vecs.push_back(mk("rw_write",    1, 0, 1, 1, 0, 32'h20, 32'h55,   32'h0,        3'b100, 0, 1, 32'h20,  32'h55,  3'b010));
      vecs.push_back(mk("rw_gap",      1, 0, 1, 0, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b010));
      vecs.push_back(mk("rw_read",     1, 0, 1, 0, 0, 32'h20, 32'h55,   32'h12345678, 3'b010, 1, 0, 32'h24,  32'h0,   3'b000));
      vecs.push_back(mk("rw_idle",     1, 0, 0, 0, 0, 32'h20, 32'h55,   32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b000));
      vecs.push_back(mk("sw_arb",      1, 0, 0, 1, 1, 32'h40, 32'hA5A5, 32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b100));
      vecs.push_back(mk("sw_wait1",    1, 0, 0, 1, 1, 32'h40, 32'hA5A5, 32'h0,        3'b100, 0, 1, 32'h40,  32'hA5A5, 3'b100));
      vecs.push_back(mk("sw_wait2",    1, 0, 0, 1, 1, 32'h40, 32'hA5A5, 32'h0,        3'b100, 0, 1, 32'h40,  32'hA5A5, 3'b100));
      vecs.push_back(mk("sw_wait3",    1, 0, 0, 1, 1, 32'h40, 32'hA5A5, 32'h0,        3'b100, 0, 1, 32'h40,  32'hA5A5, 3'b100));
      vecs.push_back(mk("sw_done",     1, 0, 0, 1, 0, 32'h40, 32'hA5A5, 32'h0,        3'b100, 0, 1, 32'h40,  32'hA5A5, 3'b000));
      vecs.push_back(mk("sw_idle",     1, 0, 0, 0, 0, 32'h40, 32'hA5A5, 32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b000));
      vecs.push_back(mk("drop_arb",    1, 0, 1, 0, 1, 32'h40, 32'hA5A5, 32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b010));
      vecs.push_back(mk("drop_xfer",   1, 0, 0, 0, 1, 32'h40, 32'hA5A5, 32'h0,        3'b010, 0, 0, 32'h24,  32'h0,   3'b000));
      vecs.push_back(mk("drop_idle",   1, 0, 0, 0, 0, 32'h40, 32'hA5A5, 32'h0,        3'b000, 0, 0, 32'h0,   32'h0,   3'b000));

      #1;
      foreach (vecs[k]) begin
         reset = vecs[k].rst; i_rd = vecs[k].i_rd; dr_rd = vecs[k].dr_rd; dw_wr = vecs[k].dw_wr;
         m_wait_req = vecs[k].mwait; i_addr = vecs[k].i_addr; dr_addr = vecs[k].dr_addr;
         dw_addr = vecs[k].dw_addr; dw_wdata = vecs[k].dw_wdata; m_rdata = vecs[k].mrdata;
         #1;
         chk({vecs[k].name, ".grant"}, 64'(grant), 64'(vecs[k].e_grant));
         chk({vecs[k].name, ".strobe"}, 64'({m_rd, m_wr}), 64'({vecs[k].e_mrd, vecs[k].e_mwr}));
         chk({vecs[k].name, ".m_addr"}, 64'(m_addr), 64'(vecs[k].e_maddr));
         chk({vecs[k].name, ".m_wdata"}, 64'(m_wdata), 64'(vecs[k].e_mwdata));
         chk({vecs[k].name, ".wait"}, 64'({dw_wait_req, dr_wait_req, i_wait_req}), 64'(vecs[k].e_wait));
         chk({vecs[k].name, ".rdata"}, 64'({i_rdata, dr_rdata}), 64'({vecs[k].mrdata, vecs[k].mrdata}));
         @(posedge clk);
         #1;
      end

      // Starvation: with limit 2, data read wins twice, then the fetch is forced through.
      i_rd = 1'b1; dr_rd = 1'b1; dw_wr = 1'b0; m_wait_req = 1'b0;
      for (int a = 0; a < 6; a++) begin
         for (int c = 0; c < 8; c++) begin
            tick();
            if (grant != 3'b000) break;
         end
         chk($sformatf("starve.arb%0d", a), 64'(grant), 64'(exp_g[a]));
         chk($sformatf("starve.strobe%0d", a), 64'({m_rd, m_wr}), 64'(2'b10));
      end
      i_rd = 1'b0; dr_rd = 1'b0;
      tick();
      tick();

      // Reset in the middle of a stalled write clears outputs without a clock edge.
      dw_wr = 1'b1; dw_addr = 32'h60; dw_wdata = 32'h77; i_rd = 1'b1; m_wait_req = 1'b1;
      tick();
      chk("midrst.grant_before", 64'(grant), 64'(3'b100));
      chk("midrst.mwr_before", 64'(m_wr), 64'(1'b1));
      #2 reset = 1'b0;
      #1;
      chk("midrst.grant_async", 64'(grant), 64'(3'b000));
      chk("midrst.strobe_async", 64'({m_rd, m_wr}), 64'(2'b00));
      chk("midrst.wait_async", 64'({dw_wait_req, dr_wait_req, i_wait_req}), 64'(3'b101));
      tick();
      reset = 1'b1; m_wait_req = 1'b0;
      #1;
      chk("midrst.idle_after", 64'(grant), 64'(3'b000));
      tick();
      chk("midrst.rearb", 64'(grant), 64'(3'b100));
      chk("midrst.m_addr", 64'(m_addr), 64'(32'h60));
      dw_wr = 1'b0; i_rd = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
